// File: rtl/sum_checker.sv
// sum_checker: consumes operand/result triplets from the sum datapath,
// recomputes a+b+c in a two-stage pipeline and counts matches/mismatches.
// After NUM_SAMPLES accepted samples it reports a pass/fail verdict.
// Optional feature macro: SUM_CHECKER_FIRSTFAIL_EN captures the operands and
// received sum of the first mismatch of a run on the fail_* ports.
module sum_checker #(
   parameter int WIDTH       = 4,
   parameter int OUT_W       = 6,
   parameter int NUM_SAMPLES = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [OUT_W-1:0] sum,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       match_cnt,
   output logic [7:0]       fail_cnt,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] fail_c,
   output logic [OUT_W-1:0] fail_sum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       smp_cnt_q, smp_cnt_d;
   logic [7:0]       match_cnt_q, match_cnt_d;
   logic [7:0]       fail_cnt_q, fail_cnt_d;
   logic             s1_vld_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;
   logic [OUT_W-1:0] s1_sum_q;
   logic [WIDTH+1:0] exp_full;
   logic [OUT_W-1:0] exp_sum;
   logic             xfer, start_run, last_xfer, s2_match;

   assign xfer      = in_valid && (state_q == S_RUN);
   assign start_run = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign last_xfer = xfer && (smp_cnt_q == 8'(NUM_SAMPLES - 1));

   // Expected sum at WIDTH+2 bits, then fitted to the result width.
   assign exp_full = {2'b00, s1_a_q} + {2'b00, s1_b_q} + {2'b00, s1_c_q};
   generate
      if (OUT_W > WIDTH + 2) begin : g_ext
         assign exp_sum = {{(OUT_W - WIDTH - 2){1'b0}}, exp_full};
      end else begin : g_trunc
         assign exp_sum = exp_full[OUT_W-1:0];
      end
   endgenerate
   assign s2_match = (exp_sum == s1_sum_q);

   // Next-state logic for the run controller.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_run) state_d = S_RUN;
         S_RUN:   if (last_xfer) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  if (start_run) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the sample counter and the saturating match/fail counters.
   always_comb begin
      smp_cnt_d   = smp_cnt_q;
      match_cnt_d = match_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      if (start_run) begin
         smp_cnt_d   = '0;
         match_cnt_d = '0;
         fail_cnt_d  = '0;
      end else begin
         if (xfer) smp_cnt_d = smp_cnt_q + 8'd1;
         if (s1_vld_q) begin
            if (s2_match) begin
               if (match_cnt_q != 8'hFF) match_cnt_d = match_cnt_q + 8'd1;
            end else begin
               if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
            end
         end
      end
   end

   // State, counters and stage-1 pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         state_q     <= S_IDLE;
         smp_cnt_q   <= '0;
         match_cnt_q <= '0;
         fail_cnt_q  <= '0;
         s1_vld_q    <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_c_q      <= '0;
         s1_sum_q    <= '0;
      end else begin
         state_q     <= state_d;
         smp_cnt_q   <= smp_cnt_d;
         match_cnt_q <= match_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         s1_vld_q    <= xfer;
         if (xfer) begin
            s1_a_q   <= a;
            s1_b_q   <= b;
            s1_c_q   <= c;
            s1_sum_q <= sum;
         end
      end
   end

`ifdef SUM_CHECKER_FIRSTFAIL_EN
   logic             ff_vld_q;
   logic [WIDTH-1:0] ff_a_q, ff_b_q, ff_c_q;
   logic [OUT_W-1:0] ff_sum_q;

   // Capture stage-2 contents of the first mismatch; held until start/reset.
   always_ff @(posedge clk) begin
      if (!rst_n || start_run) begin
         ff_vld_q <= 1'b0;
         ff_a_q   <= '0;
         ff_b_q   <= '0;
         ff_c_q   <= '0;
         ff_sum_q <= '0;
      end else if (s1_vld_q && !s2_match && !ff_vld_q) begin
         ff_vld_q <= 1'b1;
         ff_a_q   <= s1_a_q;
         ff_b_q   <= s1_b_q;
         ff_c_q   <= s1_c_q;
         ff_sum_q <= s1_sum_q;
      end
   end

   assign fail_a   = ff_a_q;
   assign fail_b   = ff_b_q;
   assign fail_c   = ff_c_q;
   assign fail_sum = ff_sum_q;
`else
   assign fail_a   = '0;
   assign fail_b   = '0;
   assign fail_c   = '0;
   assign fail_sum = '0;
`endif

   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign pass      = (state_q == S_DONE) && (fail_cnt_q == 8'd0) &&
                      (match_cnt_q == 8'(NUM_SAMPLES));
   assign match_cnt = match_cnt_q;
   assign fail_cnt  = fail_cnt_q;

endmodule
